// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT consecutive multiplier products into one
// registered result with a valid/ready output and an overflow flag.
// Optional feature macro: PRODUCT_ACCUMULATOR_SATURATE_EN (saturating adds).
module product_accumulator #(
    parameter int unsigned PW    = 8,
    parameter int unsigned ACC_W = 10,
    parameter int unsigned COUNT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PW-1:0]    p_in,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             ovf
);

    localparam int unsigned CNT_W = $clog2(COUNT);
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               ovf_q, ovf_d;

    logic [SUM_W-1:0]   add_full;
    logic [ACC_W-1:0]   add_res;
    logic               add_carry;
    logic               accept;

    // Handshake flags decode straight from state so sum_ready never reaches p_ready
    assign p_ready   = (state_q == ACCUM);
    assign sum_valid = (state_q == HOLD);
    assign sum_out   = sum_q;
    assign ovf       = ovf_q;
    assign accept    = p_valid & p_ready;

    // Adder with carry-out; wrap or saturate depending on build
    always_comb begin
        add_full  = {1'b0, acc_q} + SUM_W'(p_in);
        add_carry = add_full[ACC_W];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        add_res   = add_carry ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
        add_res   = add_full[ACC_W-1:0];
`endif
    end

    // Next-state logic: accumulate in ACCUM, hold the result in HOLD
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            ACCUM: begin
                if (clear) begin
                    // clear wins over a simultaneously accepted product
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                end else if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        sum_d     = add_res;
                        ovf_d     = ovf_acc_q | add_carry;
                        state_d   = HOLD;
                        acc_d     = '0;
                        cnt_d     = '0;
                        ovf_acc_d = 1'b0;
                    end else begin
                        acc_d     = add_res;
                        ovf_acc_d = ovf_acc_q | add_carry;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (sum_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed testbench for product_accumulator with a result scoreboard.
module tb_product_accumulator;

    localparam int unsigned PW    = 8;
    localparam int unsigned ACC_W = 10;
    localparam int unsigned COUNT = 8;
    localparam int MAXV = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [PW-1:0]    p_in;
    logic             p_valid;
    logic             p_ready;
    logic             clear;
    logic [ACC_W-1:0] sum_out;
    logic             sum_valid;
    logic             sum_ready;
    logic             ovf;

    product_accumulator #(.PW(PW), .ACC_W(ACC_W), .COUNT(COUNT)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_in      (p_in),
        .p_valid   (p_valid),
        .p_ready   (p_ready),
        .clear     (clear),
        .sum_out   (sum_out),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Expected {sum, ovf} pairs, oldest first
    int exp_sum_q[$];
    int exp_ovf_q[$];

    // Bench model of the partial accumulation (true, unbounded total)
    int m_total = 0;
    int m_cnt   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_total = 0;
        m_cnt   = 0;
    endtask

    task automatic model_accept(input int p);
        int s;
        m_total += p;
        m_cnt++;
        if (m_cnt == COUNT) begin
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
            s = (m_total > MAXV) ? MAXV : m_total;
`else
            s = m_total % (MAXV + 1);
`endif
            exp_sum_q.push_back(s);
            exp_ovf_q.push_back((m_total > MAXV) ? 1 : 0);
            model_reset();
        end
    endtask

    // Offer one product and return after the edge that accepts it
    task automatic xfer(input int p, output int waits);
        p_valid = 1'b1;
        p_in    = PW'(p);
        waits   = 0;
        while (!p_ready && waits < 20) begin
            step();
            waits++;
        end
        if (!p_ready) begin
            chk("xfer_timeout", 0, 1);
        end else begin
            step();
            model_accept(p);
        end
    endtask

    task automatic idle();
        p_valid = 1'b0;
        step();
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!sum_valid && n < 20) begin
            step();
            n++;
        end
        chk("sum_valid_timeout", int'(sum_valid), 1);
    endtask

    // Scoreboard: compare each delivered sum when the output handshake completes
    always @(negedge clk) begin
        if (!rst && sum_valid && sum_ready) begin
            if (exp_sum_q.size() == 0) begin
                chk("sb_unexpected_sum", int'(sum_out), -1);
            end else begin
                chk("sb_sum", int'(sum_out), exp_sum_q.pop_front());
                chk("sb_ovf", int'(ovf), exp_ovf_q.pop_front());
            end
        end
    end

    initial begin
        int w;
        rst = 1'b1; p_in = '0; p_valid = 1'b0; clear = 1'b0; sum_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("reset_sum_out", int'(sum_out), 0);
        chk("reset_sum_valid", int'(sum_valid), 0);
        chk("reset_ovf", int'(ovf), 0);
        chk("reset_p_ready", int'(p_ready), 1);

        // 1. Reset mid-stream discards the partial sum
        for (int i = 0; i < 3; i++) xfer(7, w);
        p_valid = 1'b0;
        rst = 1'b1; step(); step(); rst = 1'b0;
        model_reset();
        chk("midrst_sum_out", int'(sum_out), 0);
        chk("midrst_sum_valid", int'(sum_valid), 0);
        chk("midrst_ovf", int'(ovf), 0);
        chk("midrst_p_ready", int'(p_ready), 1);
        for (int i = 0; i < COUNT; i++) xfer(5, w);
        p_valid = 1'b0;
        chk("fresh_sum", int'(sum_out), 40);
        step();

        // Reset during HOLD drops the pending sum
        sum_ready = 1'b0;
        for (int i = 0; i < COUNT; i++) xfer(3, w);
        p_valid = 1'b0;
        chk("hold_before_rst", int'(sum_valid), 1);
        rst = 1'b1; step(); rst = 1'b0;
        void'(exp_sum_q.pop_back());
        void'(exp_ovf_q.pop_back());
        chk("holdrst_sum_valid", int'(sum_valid), 0);
        chk("holdrst_sum_out", int'(sum_out), 0);
        sum_ready = 1'b1;

        // 2. Basic sum with a gap after the 4th product
        for (int i = 0; i < COUNT; i++) begin
            if (i == 4) idle();
            xfer(10, w);
            if (i == COUNT - 2) chk("basic_valid_early", int'(sum_valid), 0);
        end
        p_valid = 1'b0;
        chk("basic_valid_latency", int'(sum_valid), 1);
        chk("basic_sum", int'(sum_out), 80);
        chk("basic_ovf", int'(ovf), 0);
        step();

        // 3. Overflow
        for (int i = 0; i < COUNT; i++) xfer(225, w);
        p_valid = 1'b0;
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        chk("ovf_sum", int'(sum_out), 1023);
`else
        chk("ovf_sum", int'(sum_out), 776);
`endif
        chk("ovf_flag", int'(ovf), 1);
        step();

        // 4. Backpressure: offered products are ignored while holding
        sum_ready = 1'b0;
        for (int i = 0; i < COUNT; i++) xfer(10, w);
        p_valid = 1'b1; p_in = PW'(99);
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum_out", int'(sum_out), 80);
            chk("bp_p_ready", int'(p_ready), 0);
            chk("bp_sum_valid", int'(sum_valid), 1);
            step();
        end
        p_valid = 1'b0;
        sum_ready = 1'b1;
        step();
        chk("bp_release_valid", int'(sum_valid), 0);
        chk("bp_release_ready", int'(p_ready), 1);
        for (int i = 0; i < COUNT; i++) xfer(1, w);
        p_valid = 1'b0;
        chk("bp_next_sum", int'(sum_out), 8);
        step();

        // 5. Clear drops the partial sum and a simultaneous product
        for (int i = 0; i < 3; i++) xfer(50, w);
        p_valid = 1'b1; p_in = PW'(200); clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
        sum_ready = 1'b0;
        for (int i = 0; i < COUNT; i++) xfer(2, w);
        p_valid = 1'b0;
        wait_valid();
        clear = 1'b1; step(); step(); clear = 1'b0;
        chk("clr_hold_valid", int'(sum_valid), 1);
        chk("clr_hold_sum", int'(sum_out), 16);
        sum_ready = 1'b1;
        step();

        // 6. Back-to-back with sum_ready tied high
        for (int i = 1; i <= 2 * COUNT; i++) begin
            xfer(i, w);
            chk("b2b_stall", w, (i == COUNT + 1) ? 1 : 0);
            if (i == COUNT) begin
                chk("b2b_sum1", int'(sum_out), 36);
                chk("b2b_valid1", int'(sum_valid), 1);
            end
            if (i == COUNT + 1) chk("b2b_pulse1", int'(sum_valid), 0);
        end
        p_valid = 1'b0;
        chk("b2b_sum2", int'(sum_out), 100);
        chk("b2b_valid2", int'(sum_valid), 1);
        step();
        chk("b2b_pulse2", int'(sum_valid), 0);
        step();

        chk("sb_drained", exp_sum_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Sequential stage directly downstream of the 4x4 shift-and-add multiplier.
- Consumes its 8-bit product `p`, one per valid/ready transfer, and accumulates COUNT consecutive products into one sum (dot-product style).
- Presents the sum on a registered valid/ready output, with an overflow flag.
- The register boundary isolates the combinational multiplier from downstream logic.

Parameters:
- PW, 8, product input width; matches the multiplier output `p`.
- ACC_W, 10, accumulator and sum width in bits; must be >= PW.
- COUNT, 8, number of products summed per output; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- p_in  input  PW  product from the multiplier, unsigned.
- p_valid  input  1  p_in holds a valid product.
- p_ready  output  1  block accepts p_in this cycle.
- clear  input  1  synchronous abort of the current partial accumulation.
- sum_out  output  ACC_W  accumulated sum, unsigned.
- sum_valid  output  1  sum_out and ovf are valid.
- sum_ready  input  1  downstream consumes the sum.
- ovf  output  1  overflow occurred while forming this sum.

Behaviour:
- Single clock domain `clk`; reset is synchronous, active-high on `rst`.
- All state updates on the rising edge of clk.
- Reset (rst=1 at an edge) has priority over every other input and forces:
  - state=ACCUM, acc=0, cnt=0, ovf_acc=0;
  - sum_out=0, sum_valid=0, ovf=0;
  - p_ready=1 from the first cycle after reset.
- Reset mid-operation (partial accumulation or HOLD) discards all data; no sum is emitted.
- State machine has 2 states:
  - ACCUM: p_ready=1, sum_valid=0.
  - HOLD: p_ready=0, sum_valid=1.
- p_ready is a pure function of state (no combinational path from sum_ready to p_ready).
- Accept = p_valid & p_ready.
- In ACCUM, on accept with cnt < COUNT-1:
  - acc <= acc + p_in (ACC_W bits; wrap modulo 2^ACC_W);
  - ovf_acc sets if the true sum exceeds 2^ACC_W-1;
  - cnt <= cnt+1.
- In ACCUM, on accept with cnt == COUNT-1:
  - sum_out <= acc + p_in (same arithmetic);
  - ovf <= ovf_acc | overflow of this add;
  - sum_valid <= 1, state <= HOLD, acc <= 0, cnt <= 0, ovf_acc <= 0.
- Latency: sum_valid is high the cycle after the COUNT-th accept.
- p_valid gaps are allowed; cnt counts accepts only, not cycles.
- In HOLD:
  - sum_out, ovf and sum_valid are held stable until sum_ready=1;
  - p_valid is ignored.
- In HOLD with sum_ready=1:
  - sum_valid <= 0, state <= ACCUM;
  - the next product can be accepted one cycle later (no bypass; max throughput one sum per COUNT+1 cycles).
- clear in ACCUM:
  - acc <= 0, cnt <= 0, ovf_acc <= 0;
  - a simultaneous accepted product is discarded (clear wins).
- clear in HOLD: no effect; the pending sum is still delivered.
- cnt width is $clog2(COUNT); no wrap beyond COUNT-1.
- sum_out and ovf retain their last values after handshake; only sum_valid qualifies them.

Optional Feature:
- Macro: PRODUCT_ACCUMULATOR_SATURATE_EN.
- Defined: every add saturates to 2^ACC_W-1 instead of wrapping. Once saturated, acc stays at max for the rest of the sum. ovf still reports that saturation occurred.
- Undefined: modulo-2^ACC_W wrap as described above; ovf reports wrap.

Test Plan:
1. Reset check: assert rst for 2 cycles mid-stream -> next cycle sum_out=0, sum_valid=0, ovf=0, p_ready=1; a following 8-product run yields the correct fresh sum.
2. Basic sum: eight transfers of p_in=10, with one idle cycle between the 4th and 5th -> sum_out=80, ovf=0, sum_valid rises exactly one cycle after the 8th accept.
3. Overflow: eight transfers of p_in=225 (15x15) -> without the macro, sum_out=776 and ovf=1; with PRODUCT_ACCUMULATOR_SATURATE_EN, sum_out=1023 and ovf=1.
4. Backpressure: complete a sum of 80 with sum_ready=0 for 5 cycles while p_valid=1, p_in=99 -> sum_out stays 80, p_ready=0, no product counted. Raise sum_ready -> sum_valid drops next cycle, p_ready=1; eight p_in=1 transfers then give sum_out=8.
5. Clear: accept 3 products of 50, then assert clear together with p_valid=1, p_in=200 -> that product is dropped; eight subsequent p_in=2 give sum_out=16. clear asserted during HOLD leaves the pending sum intact.
6. Back-to-back: continuous p_valid=1 with p_in = 1..16 and sum_ready=1 tied high -> sums 36 and 100 delivered, each sum_valid a 1-cycle pulse, p_ready low for exactly 1 cycle per sum.
